sd_cmd_tx: RTL and testbench
============================

# sd_cmd_tx

SD command-line transmitter that sits directly downstream of the UART front end. It accepts a 6-bit command index on a one-cycle strobe, plus a 32-bit argument. It builds the 48-bit SD command frame (start, transmission, index, argument, CRC7, end) and shifts it out MSB-first on the SD CMD line, one bit per SD clock tick. It then releases the line for the 8-clock Ncc gap and signals completion.

## Interface
Parameters:
- GAP_TICKS, 8, number of sd_clk_en ticks the line is released (cmd_oe=0, cmd_out=1) after the end bit, before done.

Ports:
- ex_clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sd_clk_en  input  1  one-ex_clk-cycle tick marking each SD clock bit period; the bit shifter advances only on ticks.
- cmd_en  input  1  one-cycle strobe requesting a command; connects to the UART's uart_cmd_en.
- cmd_index  input  6  command index; connects to uart_cmd; sampled when cmd_en is accepted.
- cmd_arg  input  32  command argument; sampled together with cmd_index.
- cmd_out  output  1  serial CMD line data.
- cmd_oe  output  1  CMD line output enable; 1 only while frame bits are driven.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when the gap completes.

## Operation
- States: IDLE, WAIT_TICK, SHIFT, GAP.
- IDLE: cmd_en=1 latches the frame's first 40 bits {1'b0, 1'b1, cmd_index, cmd_arg} into the shift register, clears CRC to 0 and the bit counter to 0, and moves to WAIT_TICK; busy=1 next cycle.
- WAIT_TICK: on the first sd_clk_en tick, drive bit 47 (start bit 0) with cmd_oe=1; go to SHIFT.
- SHIFT: each tick drives the next bit; the bit counter runs 0..47.
  - Bits 47..8 come from the shift register.
  - Bits 7..1 come from the CRC7 register, MSB first.
  - Bit 0 is the end bit 1.
- CRC7: polynomial x^7+x^3+1, initial value 0. Update on each of the 40 header/argument bits as they are driven:
  - fb = bit ^ crc[6]
  - crc = {crc[5:3], crc[2]^fb, crc[1:0], fb}
- CRC freezes before bit 7 is driven.
- On the tick after the end bit: cmd_oe=0, cmd_out=1; go to GAP with the tick counter cleared.
- GAP: count GAP_TICKS ticks. On the last one, pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
- cmd_en while busy=1 is ignored, with no queuing; the latched index and argument are unaffected.
- cmd_en in the done cycle is ignored. cmd_en in the first IDLE cycle after done is accepted.
- cmd_index and cmd_arg changing after acceptance have no effect.
- sd_clk_en asserted on the acceptance cycle itself does not count; the first usable tick is the next one.

## Timing
- Reset values: cmd_out=1, cmd_oe=0, busy=0, done=0; state=IDLE; counters and CRC=0.
- Reset mid-frame or mid-gap: outputs return to reset values immediately (asynchronously); no done pulse.
- Latency:
  - Acceptance to the start bit: the first tick after acceptance.
  - Start bit to end bit: 47 ticks.
  - End bit to line release: 1 tick.
  - Release to done: GAP_TICKS ticks.
- Ticks to done: 49+GAP_TICKS ticks after the acceptance cycle, i.e. 57 ticks with the default.
- All outputs are registered. cmd_out and cmd_oe change only in the cycle a tick is sampled, appearing the next ex_clk edge.
- cmd_out holds between ticks. Any tick spacing of at least 1 cycle is supported, including a continuous tick (sd_clk_en=1).

## Test plan
- CMD0, arg 0x00000000, sd_clk_en continuous -> 48 bits on cmd_out equal 0x400000000095 (CRC7 0x4A); cmd_oe high for exactly 48 ticks; then 8 ticks of cmd_out=1, cmd_oe=0; then done pulse; busy high 57 ticks.
- CMD8, arg 0x000001AA, ticks every 5208 cycles -> frame 0x48000001AA87 (CRC7 0x43); bits stable between ticks.
- CMD17, arg 0 -> frame 0x510000000055 (CRC7 0x2A). Second cmd_en at bit 20 with index 5 -> ignored, frame unchanged, a single done.
- cmd_en in the done cycle -> ignored. cmd_en one cycle later -> accepted, busy=1 next cycle, start bit on the next tick.
- Reset asserted at bit 30 -> cmd_out=1, cmd_oe=0, busy=0 immediately; no done. A new CMD0 afterwards -> correct 0x...95 frame (CRC reinitialised).
- Tick coincident with the cmd_en acceptance cycle -> not used; the start bit appears on the following tick.

Source files
------------

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: frames a 6-bit index and a 32-bit argument with CRC7.
// The frame is shifted out MSB-first on SD clock ticks, followed by the Ncc release gap.
module sd_cmd_tx #(
   parameter int unsigned GAP_TICKS = 8
) (
   input  logic        ex_clk,
   input  logic        reset,
   input  logic        sd_clk_en,
   input  logic        cmd_en,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   output logic        cmd_out,
   output logic        cmd_oe,
   output logic        busy,
   output logic        done
);

   localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      SHIFT,
      GAP
   } state_e;

   state_e             state_q, state_d;
   logic [39:0]        shreg_q, shreg_d;
   logic [6:0]         crc_q, crc_d;
   logic [5:0]         bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               cmd_out_q, cmd_out_d;
   logic               cmd_oe_q, cmd_oe_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2:0]         crc_sel;

   // CRC7, polynomial x^7 + x^3 + 1, one data bit per call.
   function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[6];
      return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
   endfunction

   // bit_cnt_q is the frame position already driven, so the CRC bit coming next is index 6 - crc_sel.
   assign crc_sel = 3'(bit_cnt_q - 6'd39);

   always_comb begin
      // NOTE: every _d takes its held value first so no path through the case leaves a latch.
      state_d   = state_q;
      shreg_d   = shreg_q;
      crc_d     = crc_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      cmd_out_d = cmd_out_q;
      cmd_oe_d  = cmd_oe_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // The done cycle is already IDLE but must not accept a new command.
            if (cmd_en && !done_q) begin
               shreg_d   = {1'b0, 1'b1, cmd_index, cmd_arg};
               crc_d     = '0;
               bit_cnt_d = '0;
               gap_cnt_d = '0;
               busy_d    = 1'b1;
               state_d   = WAIT_TICK;
            end
         end

         WAIT_TICK: begin
            if (sd_clk_en) begin
               cmd_out_d = shreg_q[39];
               cmd_oe_d  = 1'b1;
               crc_d     = crc7_next(crc_q, shreg_q[39]);
               shreg_d   = {shreg_q[38:0], 1'b0};
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            if (sd_clk_en) begin
               if (bit_cnt_q == 6'd47) begin
                  cmd_out_d = 1'b1;
                  cmd_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q < 6'd39) begin
                     cmd_out_d = shreg_q[39];
                     crc_d     = crc7_next(crc_q, shreg_q[39]);
                     shreg_d   = {shreg_q[38:0], 1'b0};
                  end else if (bit_cnt_q < 6'd46) begin
                     cmd_out_d = crc_q[3'd6 - crc_sel];
                  end else begin
                     cmd_out_d = 1'b1;
                  end
               end
            end
         end

         GAP: begin
            if (sd_clk_en) begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_d = '0;
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: the shift register is reset along with the rest; it is small and keeps the state deterministic.
   always_ff @(posedge ex_clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         crc_q     <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         cmd_out_q <= 1'b1;
         cmd_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of its neighbours.
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         crc_q     <= crc_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         cmd_out_q <= cmd_out_d;
         cmd_oe_q  <= cmd_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign cmd_out = cmd_out_q;
   assign cmd_oe  = cmd_oe_q;
   assign busy    = busy_q;
   assign done    = done_q;

   a_done_not_busy : assert property (@(posedge ex_clk) disable iff (reset) done_q |-> !busy_q);
   a_oe_only_busy  : assert property (@(posedge ex_clk) disable iff (reset) cmd_oe_q |-> busy_q);

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: known SD command frames with hand-computed CRC7,
// plus done-cycle, busy-drop, tick-on-acceptance and mid-frame reset scenarios.
module tb_sd_cmd_tx;

   logic        ex_clk;
   logic        reset;
   logic        sd_clk_en;
   logic        cmd_en;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_out;
   logic        cmd_oe;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_pass   = 0;

   sd_cmd_tx #(.GAP_TICKS(8)) dut (
      .ex_clk    (ex_clk),
      .reset     (reset),
      .sd_clk_en (sd_clk_en),
      .cmd_en    (cmd_en),
      .cmd_index (cmd_index),
      .cmd_arg   (cmd_arg),
      .cmd_out   (cmd_out),
      .cmd_oe    (cmd_oe),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      ex_clk = 1'b0;
      forever #5 ex_clk = ~ex_clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One ex_clk cycle; inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step(input logic tick);
      sd_clk_en = tick;
      @(posedge ex_clk);
      #1;
   endtask

   // Accepts one command, then applies 57 ticks spaced s cycles apart and checks the whole transaction.
   task automatic run_frame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                            input int s, input bit tick_acc, input int inj_t,
                            input logic [47:0] exp_frame);
      logic [47:0] frame;
      logic [1:0]  prev;
      int          oe_n, busy_n, done_n;
      bit          gap_bad, hold_bad;
      frame = '0; oe_n = 0; busy_n = 0; done_n = 0; gap_bad = 0; hold_bad = 0;

      cmd_index = idx;
      cmd_arg   = arg;
      cmd_en    = 1'b1;
      step(tick_acc);
      cmd_en    = 1'b0;
      cmd_index = ~idx;
      cmd_arg   = ~arg;
      check({tag, "_busy_acc"}, 64'(busy), 64'd1);
      check({tag, "_oe_acc"}, 64'(cmd_oe), 64'd0);
      busy_n += int'(busy);
      prev = {cmd_oe, cmd_out};

      for (int t = 1; t <= 57; t++) begin
         for (int k = 1; k < s; k++) begin
            step(1'b0);
            busy_n += int'(busy);
            done_n += int'(done);
            if ({cmd_oe, cmd_out} !== prev) hold_bad = 1'b1;
         end
         if (t == inj_t) begin
            cmd_en    = 1'b1;
            cmd_index = 6'd5;
            cmd_arg   = 32'hdead_beef;
         end
         step(1'b1);
         cmd_en = 1'b0;
         if (t < 57) begin
            busy_n += int'(busy);
            done_n += int'(done);
         end
         oe_n += int'(cmd_oe);
         if (t <= 48) frame = {frame[46:0], cmd_out};
         else if (t <= 56 && (cmd_out !== 1'b1 || cmd_oe !== 1'b0)) gap_bad = 1'b1;
         prev = {cmd_oe, cmd_out};
      end

      check({tag, "_frame"}, 64'(frame), 64'(exp_frame));
      check({tag, "_oe_ticks"}, 64'(oe_n), 64'd48);
      check({tag, "_gap_bad"}, 64'(gap_bad), 64'd0);
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(57 * s));
      check({tag, "_early_done"}, 64'(done_n), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_line_end"}, 64'({cmd_oe, cmd_out}), 64'b01);
      if (s > 1) check({tag, "_hold"}, 64'(hold_bad), 64'd0);
   endtask

   initial begin
      int done_n;
      reset     = 1'b1;
      sd_clk_en = 1'b0;
      cmd_en    = 1'b0;
      cmd_index = '0;
      cmd_arg   = '0;
      repeat (3) @(posedge ex_clk);
      #1;
      check("rst_cmd_out", 64'(cmd_out), 64'd1);
      check("rst_cmd_oe", 64'(cmd_oe), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset = 1'b0;
      repeat (2) step(1'b1);

      // CMD0 with a continuous tick.
      run_frame("cmd0", 6'd0, 32'h0000_0000, 1, 1'b0, 0, 48'h4000_0000_0095);

      // cmd_en in the done cycle is dropped; the pulse lasts a single cycle.
      cmd_en    = 1'b1;
      cmd_index = 6'd8;
      step(1'b1);
      cmd_en = 1'b0;
      check("donecyc_busy", 64'(busy), 64'd0);
      check("donecyc_done", 64'(done), 64'd0);
      check("donecyc_oe", 64'(cmd_oe), 64'd0);

      // Accepted in the first IDLE cycle after done; sparse ticks test hold between ticks.
      run_frame("cmd8", 6'd8, 32'h0000_01AA, 50, 1'b0, 0, 48'h4800_0001_AA87);
      repeat (3) step(1'b0);

      // Tick coincident with acceptance, and a second cmd_en at bit 20 that must be ignored.
      run_frame("cmd17", 6'd17, 32'h0000_0000, 3, 1'b1, 20, 48'h5100_0000_0055);
      repeat (2) step(1'b0);

      // Reset asserted at bit 30 of a CMD0 frame.
      cmd_index = 6'd0;
      cmd_arg   = 32'h0;
      cmd_en    = 1'b1;
      step(1'b0);
      cmd_en = 1'b0;
      repeat (30) step(1'b1);
      check("midrst_pre_oe", 64'(cmd_oe), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("midrst_cmd_out", 64'(cmd_out), 64'd1);
      check("midrst_cmd_oe", 64'(cmd_oe), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      @(posedge ex_clk);
      #1 reset = 1'b0;
      done_n = 0;
      for (int i = 0; i < 70; i++) begin
         step(1'b1);
         done_n += int'(done);
      end
      check("midrst_no_done", 64'(done_n), 64'd0);
      check("midrst_idle_busy", 64'(busy), 64'd0);

      // CRC must restart from zero after the aborted frame.
      run_frame("cmd0b", 6'd0, 32'h0000_0000, 2, 1'b0, 0, 48'h4000_0000_0095);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
